maxpool2d_layer1: RTL and testbench

- 2x2, stride-2 max-pooling stage directly downstream of conv2d_layer1.
- Consumes its 8 parallel channel streams (out_valid plus out_conv0..7), row-major, one pixel position per valid cycle.
- Emits one pooled value per channel for every 2x2 window, also row-major, for consumption by the next layer.
- Uses one half-width line buffer per channel; no backpressure.

---
 rtl/maxpool2d_layer1.sv | 127 ++++++++++++
 tb/tb_maxpool2d_layer1.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2d_layer1.sv
// 2x2 stride-2 max-pooling over 8 parallel channel streams, row-major input and output.
// Define MAXPOOL_SIGNED_EN to compare samples as signed two's complement instead of unsigned.
module maxpool2d_layer1 #(
  parameter int IMG_W  = 4,
  parameter int IMG_H  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  input  logic [DATA_W-1:0] in_data3,
  input  logic [DATA_W-1:0] in_data4,
  input  logic [DATA_W-1:0] in_data5,
  input  logic [DATA_W-1:0] in_data6,
  input  logic [DATA_W-1:0] in_data7,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_pool0,
  output logic [DATA_W-1:0] out_pool1,
  output logic [DATA_W-1:0] out_pool2,
  output logic [DATA_W-1:0] out_pool3,
  output logic [DATA_W-1:0] out_pool4,
  output logic [DATA_W-1:0] out_pool5,
  output logic [DATA_W-1:0] out_pool6,
  output logic [DATA_W-1:0] out_pool7,
  output logic              frame_done
);

  localparam int NCH  = 8;
  localparam int CW   = (IMG_W > 4) ? $clog2(IMG_W) : 2;
  localparam int RW   = (IMG_H > 4) ? $clog2(IMG_H) : 2;
  localparam int LB_D = 2 ** (CW - 1);

  localparam logic [CW-1:0] COL_LAST     = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_H - 1);
  // Coordinates of the window-completing pixel of the last full window (floor semantics).
  localparam logic [CW-1:0] COL_OUT_LAST = CW'((IMG_W / 2) * 2 - 1);
  localparam logic [RW-1:0] ROW_OUT_LAST = RW'((IMG_H / 2) * 2 - 1);

  function automatic logic [DATA_W-1:0] vmax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
`ifdef MAXPOOL_SIGNED_EN
    return ($signed(b) > $signed(a)) ? b : a;
`else
    return (b > a) ? b : a;
`endif
  endfunction

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [CW-2:0]     lb_idx;
  logic              emit;
  logic              lb_wr;
  logic [DATA_W-1:0] din      [NCH];
  logic [DATA_W-1:0] pair_q   [NCH];
  logic [DATA_W-1:0] pair_max [NCH];
  logic [DATA_W-1:0] win_max  [NCH];
  logic [DATA_W-1:0] pool_q   [NCH];
  logic [DATA_W-1:0] linebuf  [NCH][LB_D];

  assign din[0] = in_data0;
  assign din[1] = in_data1;
  assign din[2] = in_data2;
  assign din[3] = in_data3;
  assign din[4] = in_data4;
  assign din[5] = in_data5;
  assign din[6] = in_data6;
  assign din[7] = in_data7;

  assign out_pool0 = pool_q[0];
  assign out_pool1 = pool_q[1];
  assign out_pool2 = pool_q[2];
  assign out_pool3 = pool_q[3];
  assign out_pool4 = pool_q[4];
  assign out_pool5 = pool_q[5];
  assign out_pool6 = pool_q[6];
  assign out_pool7 = pool_q[7];

  // Column pair index; an odd trailing column never reaches an odd col, so it is never used.
  assign lb_idx = col[CW-1:1];
  assign emit   = in_valid & row[0] & col[0];
  assign lb_wr  = in_valid & ~row[0] & col[0];

  // NOTE: every array element is assigned on each pass, so no latch can be inferred.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      pair_max[c] = vmax(pair_q[c], din[c]);
      win_max[c]  = vmax(linebuf[c][lb_idx], pair_max[c]);
    end
  end

  // NOTE: pair and line-buffer storage carry no reset; each entry is written before it is read.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (in_valid && !col[0]) pair_q[c] <= din[c];
      if (lb_wr) linebuf[c][lb_idx] <= pair_max[c];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int c = 0; c < NCH; c++) pool_q[c] <= '0;
    end else begin
      out_valid  <= emit;
      frame_done <= emit && (row == ROW_OUT_LAST) && (col == COL_OUT_LAST);
      if (emit) begin
        for (int c = 0; c < NCH; c++) pool_q[c] <= win_max[c];
      end
      if (in_valid) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool2d_layer1.sv
// Scoreboard bench for maxpool2d_layer1: a 4x4 instance and a 5x4 (odd width) instance,
// each checked against a window-maximum model computed from whole-frame pixel arrays.
module tb_maxpool2d_layer1;

  typedef struct {
    logic [63:0] v;
    logic        fd;
    int          cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       va, vb;
  logic [7:0] da [8];
  logic [7:0] db [8];
  logic [7:0] pa [8];
  logic [7:0] pb [8];
  logic       vo_a, vo_b, fdo_a, fdo_b;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int pulses_a = 0, pulses_b = 0, fds_a = 0, fds_b = 0;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [63:0] last_a, last_b;

  int          mw [2];
  int          mh [2];
  int          mr [2];
  int          mc [2];
  logic [63:0] img [2][8][8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  maxpool2d_layer1 #(.IMG_W(4), .IMG_H(4), .DATA_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(va),
    .in_data0(da[0]), .in_data1(da[1]), .in_data2(da[2]), .in_data3(da[3]),
    .in_data4(da[4]), .in_data5(da[5]), .in_data6(da[6]), .in_data7(da[7]),
    .out_valid(vo_a),
    .out_pool0(pa[0]), .out_pool1(pa[1]), .out_pool2(pa[2]), .out_pool3(pa[3]),
    .out_pool4(pa[4]), .out_pool5(pa[5]), .out_pool6(pa[6]), .out_pool7(pa[7]),
    .frame_done(fdo_a)
  );

  maxpool2d_layer1 #(.IMG_W(5), .IMG_H(4), .DATA_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(vb),
    .in_data0(db[0]), .in_data1(db[1]), .in_data2(db[2]), .in_data3(db[3]),
    .in_data4(db[4]), .in_data5(db[5]), .in_data6(db[6]), .in_data7(db[7]),
    .out_valid(vo_b),
    .out_pool0(pb[0]), .out_pool1(pb[1]), .out_pool2(pb[2]), .out_pool3(pb[3]),
    .out_pool4(pb[4]), .out_pool5(pb[5]), .out_pool6(pb[6]), .out_pool7(pb[7]),
    .frame_done(fdo_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pack8(input logic [7:0] p [8]);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = p[k];
    return r;
  endfunction

  // Sample value as a number on the chosen comparison scale.
  function automatic int sval(input logic [7:0] v);
`ifdef MAXPOOL_SIGNED_EN
    return (v >= 8'd128) ? int'(v) - 256 : int'(v);
`else
    return int'(v);
`endif
  endfunction

  function automatic logic [7:0] mx(input logic [7:0] a, input logic [7:0] b);
    return (sval(b) > sval(a)) ? b : a;
  endfunction

  function automatic logic [63:0] basic_px(input int p, input bit rev);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = 8'((k == 0 && rev) ? 17 - p : p + 16 * k);
    return r;
  endfunction

  function automatic logic [63:0] rand_px();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r;
  endfunction

  // Drive one pixel, record it in the frame image and queue the window result it completes.
  task automatic send_pix(input int id, input logic [63:0] px, input int gaps);
    int r, c, wp, hp;
    exp_t e;
    logic [63:0] w0, w1, w2;
    r = mr[id];
    c = mc[id];
    wp = 2 * (mw[id] / 2);
    hp = 2 * (mh[id] / 2);
    img[id][r][c] = px;
    for (int k = 0; k < 8; k++) begin
      if (id == 0) da[k] = px[8*k +: 8];
      else         db[k] = px[8*k +: 8];
    end
    if (id == 0) va = 1'b1;
    else         vb = 1'b1;
    if (r % 2 == 1 && c % 2 == 1 && c < wp && r < hp) begin
      w0 = img[id][r-1][c-1];
      w1 = img[id][r-1][c];
      w2 = img[id][r][c-1];
      for (int k = 0; k < 8; k++)
        e.v[8*k +: 8] = mx(mx(w0[8*k +: 8], w1[8*k +: 8]), mx(w2[8*k +: 8], px[8*k +: 8]));
      e.fd  = (r == hp - 1) && (c == wp - 1);
      e.cyc = cyc + 1;
      if (id == 0) qa.push_back(e);
      else         qb.push_back(e);
    end
    c++;
    if (c == mw[id]) begin
      c = 0;
      r = (r == mh[id] - 1) ? 0 : r + 1;
    end
    mr[id] = r;
    mc[id] = c;
    @(negedge clk);
    if (id == 0) va = 1'b0;
    else         vb = 1'b0;
    repeat (gaps) @(negedge clk);
  endtask

  task automatic send_frame(input int id, input bit rev, input int gaps);
    for (int p = 1; p <= mw[id] * mh[id]; p++) send_pix(id, basic_px(p, rev), gaps);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(name, 64'(qa.size() + qb.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mr[i] = 0;
      mc[i] = 0;
    end
    last_a = '0;
    last_b = '0;
    #1;
    check("rst_valid_a", 64'(vo_a), 64'd0);
    check("rst_done_a", 64'(fdo_a), 64'd0);
    check("rst_pool_a", pack8(pa), 64'd0);
    check("rst_pool_b", pack8(pb), 64'd0);
    @(negedge clk);
    check("rst_hold_pool_a", pack8(pa), 64'd0);
    check("rst_hold_valid_b", 64'(vo_b | fdo_b), 64'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Monitors: pop the scoreboard on every output pulse, otherwise require held outputs.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (vo_a) begin
        n_checks++;
        if (qa.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pulse_a: got pulse expected none (cycle %0d)", cyc);
        end else begin
          e = qa.pop_front();
          check("latency_a", 64'(cyc), 64'(e.cyc));
          check("pool_a", pack8(pa), e.v);
          check("frame_done_a", 64'(fdo_a), 64'(e.fd));
          last_a = e.v;
          pulses_a++;
          if (fdo_a) fds_a++;
        end
      end else begin
        check("idle_done_a", 64'(fdo_a), 64'd0);
        check("hold_a", pack8(pa), last_a);
      end
      if (vo_b) begin
        n_checks++;
        if (qb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pulse_b: got pulse expected none (cycle %0d)", cyc);
        end else begin
          e = qb.pop_front();
          check("latency_b", 64'(cyc), 64'(e.cyc));
          check("pool_b", pack8(pb), e.v);
          check("frame_done_b", 64'(fdo_b), 64'(e.fd));
          last_b = e.v;
          pulses_b++;
          if (fdo_b) fds_b++;
        end
      end else begin
        check("idle_done_b", 64'(fdo_b), 64'd0);
        check("hold_b", pack8(pb), last_b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0, f0;
    logic [63:0] px;
    logic [7:0]  sgn [4];
    rst_n = 1'b0;
    va = 1'b0;
    vb = 1'b0;
    for (int k = 0; k < 8; k++) begin
      da[k] = '0;
      db[k] = '0;
    end
    mw[0] = 4; mh[0] = 4;
    mw[1] = 5; mh[1] = 4;
    last_a = '0;
    last_b = '0;
    repeat (2) @(negedge clk);
    do_reset();

    // Basic 4x4 frame, no gaps.
    p0 = pulses_a; f0 = fds_a;
    send_frame(0, 1'b0, 0);
    wait_drain("drain_basic");
    check("basic_pulses", 64'(pulses_a - p0), 64'd4);
    check("basic_frame_done", 64'(fds_a - f0), 64'd1);
    check("basic_last_ch7", 64'(pa[7]), 64'd128);

    // Same frame with three idle cycles after every pixel.
    p0 = pulses_a;
    send_frame(0, 1'b0, 3);
    wait_drain("drain_gapped");
    check("gapped_pulses", 64'(pulses_a - p0), 64'd4);

    // Back-to-back frames, second one reversed on channel 0.
    p0 = pulses_a; f0 = fds_a;
    send_frame(0, 1'b0, 0);
    send_frame(0, 1'b1, 0);
    wait_drain("drain_b2b");
    check("b2b_pulses", 64'(pulses_a - p0), 64'd8);
    check("b2b_frame_done", 64'(fds_a - f0), 64'd2);
    check("b2b_last_ch0", 64'(pa[0]), 64'd6);

    // Reset after six accepted pixels, then a full frame.
    for (int p = 1; p <= 6; p++) send_pix(0, basic_px(p, 1'b0), 0);
    wait_drain("drain_partial");
    do_reset();
    p0 = pulses_a; f0 = fds_a;
    send_frame(0, 1'b0, 0);
    wait_drain("drain_after_reset");
    check("reset_pulses", 64'(pulses_a - p0), 64'd4);
    check("reset_frame_done", 64'(fds_a - f0), 64'd1);

    // Signedness window on channel 0: pixels 1, 2, 5, 6 form the first window.
    sgn[0] = 8'h80; sgn[1] = 8'h01; sgn[2] = 8'h81; sgn[3] = 8'h02;
    for (int p = 1; p <= 16; p++) begin
      px = rand_px();
      if (p == 1) px[7:0] = sgn[0];
      if (p == 2) px[7:0] = sgn[1];
      if (p == 5) px[7:0] = sgn[2];
      if (p == 6) px[7:0] = sgn[3];
      send_pix(0, px, 0);
`ifdef MAXPOOL_SIGNED_EN
      if (p == 6) check("signed_window", 64'(pa[0]), 64'h02);
`else
      if (p == 6) check("unsigned_window", 64'(pa[0]), 64'h81);
`endif
    end
    wait_drain("drain_sign");

    // Random frames with random gaps on both instances.
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < 16; p++) send_pix(0, rand_px(), $urandom_range(0, 2));
      for (int p = 0; p < 20; p++) send_pix(1, rand_px(), $urandom_range(0, 1));
    end
    wait_drain("drain_random");

    // Odd width 5x4: column 4 is ignored.
    p0 = pulses_b; f0 = fds_b;
    send_frame(1, 1'b0, 0);
    wait_drain("drain_odd");
    check("odd_pulses", 64'(pulses_b - p0), 64'd4);
    check("odd_frame_done", 64'(fds_b - f0), 64'd1);
    check("odd_last_ch0", 64'(pb[0]), 64'd19);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
